// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU sharing arbiter.
package alu_share_pkg;

  localparam int ALU_A_W   = 2;
  localparam int ALU_SEL_W = 2;
  localparam int ALU_RES_W = 4;
  localparam int TAG_ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // The id field is sized for the largest supported requester count (8).
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int id_width(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Request arbiter: round-robin with ALU_SHARE_ARBITER_RR_EN defined,
// fixed lowest-index priority otherwise. Grants only while in RUN.
module alu_rr_arbiter
  import alu_share_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic [1:0]       state,
  output logic [N_REQ-1:0] grant
);

  localparam int PW = $clog2(N_REQ);

  logic          found;
  logic [PW-1:0] win_idx;

`ifdef ALU_SHARE_ARBITER_RR_EN
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;

  // Search starts just after the last granted requester.
  always_comb begin
    found   = 1'b0;
    win_idx = ptr;
    idx     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = PW'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PW'(N_REQ - 1);
    end else if (advance) begin
      ptr <= win_idx;
    end
  end
`else
  logic unused_fixed;
  assign unused_fixed = &{1'b0, clk, rst_n, advance};

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found   = 1'b1;
        win_idx = PW'(i);
      end
    end
  end
`endif

  assign grant = (state == RUN && found) ? (N_REQ'(1) << win_idx) : '0;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one pipelined ALU among N_REQ requesters and returns id-tagged results.
// Arbitration policy selected by ALU_SHARE_ARBITER_RR_EN (round-robin when defined).
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int LAT   = 2,
  localparam int IDW   = id_width(N_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [ALU_A_W*N_REQ-1:0]   i_req_a,
  input  logic [ALU_SEL_W*N_REQ-1:0] i_req_select,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_alu_valid,
  output logic [ALU_A_W-1:0]         o_alu_a,
  output logic [ALU_SEL_W-1:0]       o_alu_select,
  input  logic [ALU_RES_W-1:0]       i_alu_result,
  output logic                       o_rsp_valid,
  output logic [IDW-1:0]             o_rsp_id,
  output logic [ALU_RES_W-1:0]       o_rsp_result,
  output logic                       o_idle,
  output logic [2:0]                 o_inflight,
  output logic [1:0]                 o_state
);

  // Handshake: a request is accepted at a rising edge where i_req_valid[w] and
  // o_req_ready[w] are both high; ready may depend on valid; responses have no
  // backpressure and o_rsp_valid is a one-cycle strobe.

  arb_state_t             state;
  logic [N_REQ-1:0]       grant;
  logic                   accept;
  logic                   rsp_fire;
  logic [IDW-1:0]         win_id;
  logic [ALU_A_W-1:0]     win_a;
  logic [ALU_SEL_W-1:0]   win_sel;
  tag_t                   tags [0:LAT];

  // Masking with i_en ensures no grant on the edge where enable falls.
  alu_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .req     (i_req_valid & {N_REQ{i_en}}),
    .advance (accept),
    .state   (state),
    .grant   (grant)
  );

  assign o_req_ready = grant;
  assign accept      = |(i_req_valid & grant);
  assign rsp_fire    = tags[LAT].valid;
  assign o_state     = state;

  always_comb begin
    win_id  = '0;
    win_a   = '0;
    win_sel = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (grant[r]) begin
        win_id  = IDW'(r);
        win_a   = i_req_a[ALU_A_W*r +: ALU_A_W];
        win_sel = i_req_select[ALU_SEL_W*r +: ALU_SEL_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      o_idle <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (i_en) begin
            state  <= RUN;
            o_idle <= 1'b0;
          end
        end
        RUN: begin
          if (!i_en) state <= DRAIN;
        end
        DRAIN: begin
          if (o_inflight == 3'd0) begin
            if (i_en) begin
              state <= RUN;
            end else begin
              state  <= IDLE;
              o_idle <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_idle <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alu_valid  <= 1'b0;
      o_alu_a      <= '0;
      o_alu_select <= '0;
    end else begin
      o_alu_valid <= accept;
      if (accept) begin
        o_alu_a      <= win_a;
        o_alu_select <= win_sel;
      end
    end
  end

  // Tag pipeline has no stalls: stage LAT lines up with the result edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: accept, id: TAG_ID_W'(win_id)};
      for (int i = 1; i <= LAT; i++) tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid  <= 1'b0;
      o_rsp_id     <= '0;
      o_rsp_result <= '0;
    end else begin
      o_rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        o_rsp_id     <= IDW'(tags[LAT].id);
        o_rsp_result <= i_alu_result;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inflight <= 3'd0;
    end else begin
      case ({accept, rsp_fire})
        2'b10:   o_inflight <= o_inflight + 3'd1;
        2'b01:   o_inflight <= o_inflight - 3'd1;
        default: o_inflight <= o_inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: random and directed traffic checked against a
// queue-based reference model; a second instance covers the zero-latency case.
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int LAT_A = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A (LAT=2) ----------------
  logic       en = 1'b0;
  logic [3:0] req_valid = '0;
  logic [7:0] req_a = '0;
  logic [7:0] req_sel = '0;
  logic [3:0] req_ready;
  logic       alu_valid;
  logic [1:0] alu_a, alu_sel;
  logic [3:0] alu_result;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [3:0] rsp_result;
  logic       idle;
  logic [2:0] inflight;
  logic [1:0] state;
  logic [3:0] stub_s1, stub_s2;

  alu_share_arbiter #(.N_REQ(4), .LAT(LAT_A)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_req_valid(req_valid), .i_req_a(req_a), .i_req_select(req_sel),
    .o_req_ready(req_ready), .o_alu_valid(alu_valid), .o_alu_a(alu_a),
    .o_alu_select(alu_sel), .i_alu_result(alu_result), .o_rsp_valid(rsp_valid),
    .o_rsp_id(rsp_id), .o_rsp_result(rsp_result), .o_idle(idle),
    .o_inflight(inflight), .o_state(state)
  );

  // ALU stub: returns {select, a} two cycles after issue.
  always @(posedge clk) begin
    stub_s1 <= {alu_sel, alu_a};
    stub_s2 <= stub_s1;
  end
  assign alu_result = stub_s2;

  // ---------------- instance B (LAT=0) ----------------
  logic       b_en = 1'b0;
  logic [3:0] b_req_valid = '0;
  logic [7:0] b_req_a = '0;
  logic [7:0] b_req_sel = '0;
  logic [3:0] b_req_ready;
  logic       b_alu_valid;
  logic [1:0] b_alu_a, b_alu_sel;
  logic       b_rsp_valid;
  logic [1:0] b_rsp_id;
  logic [3:0] b_rsp_result;
  logic       b_idle;
  logic [2:0] b_inflight;
  logic [1:0] b_state;

  alu_share_arbiter #(.N_REQ(4), .LAT(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en),
    .i_req_valid(b_req_valid), .i_req_a(b_req_a), .i_req_select(b_req_sel),
    .o_req_ready(b_req_ready), .o_alu_valid(b_alu_valid), .o_alu_a(b_alu_a),
    .o_alu_select(b_alu_sel), .i_alu_result({b_alu_sel, b_alu_a}),
    .o_rsp_valid(b_rsp_valid), .o_rsp_id(b_rsp_id), .o_rsp_result(b_rsp_result),
    .o_idle(b_idle), .o_inflight(b_inflight), .o_state(b_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  arb_state_t m_state = IDLE;
  int         m_ptr   = 3;
  logic [5:0] exp_q[$];   // {id, select, a} of each accepted operation
  int         due_q[$];   // edge number at which its response is captured
  logic [1:0] m_alu_a = '0, m_alu_sel = '0;
  logic [1:0] m_rsp_id = '0;
  logic [3:0] m_rsp_res = '0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(logic [3:0] v);
`ifdef ALU_SHARE_ARBITER_RR_EN
    for (int i = 1; i <= 4; i++) if (v[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
`else
    for (int i = 0; i < 4; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  // One clock of instance A: check ready, advance the model, check outputs.
  task automatic step();
    int         w;
    bit         acc;
    bit         empty_pre;
    bit         rsp_v;
    logic [1:0] a_w, s_w;
    logic [5:0] r;
    #1;
    w = -1;
    if (m_state == RUN && en) w = pick(req_valid);
    acc = (w >= 0);
    check("ready", req_ready, acc ? 4'(1 << w) : 4'b0);
    a_w = acc ? req_a[2*w +: 2] : 2'b0;
    s_w = acc ? req_sel[2*w +: 2] : 2'b0;
    empty_pre = (exp_q.size() == 0);
    @(posedge clk);
    cyc++;
    rsp_v = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      r = exp_q.pop_front();
      void'(due_q.pop_front());
      rsp_v = 1'b1;
      m_rsp_id  = r[5:4];
      m_rsp_res = r[3:0];
    end
    if (acc) begin
      exp_q.push_back({2'(w), s_w, a_w});
      due_q.push_back(cyc + LAT_A + 1);
      m_ptr     = w;
      m_alu_a   = a_w;
      m_alu_sel = s_w;
    end
    case (m_state)
      IDLE:    if (en) m_state = RUN;
      RUN:     if (!en) m_state = DRAIN;
      default: if (empty_pre) m_state = en ? RUN : IDLE;
    endcase
    #1;
    check("alu_valid", alu_valid, acc);
    check("alu_a", alu_a, m_alu_a);
    check("alu_sel", alu_sel, m_alu_sel);
    check("rsp_valid", rsp_valid, rsp_v);
    check("rsp_id", rsp_id, m_rsp_id);
    check("rsp_result", rsp_result, m_rsp_res);
    check("inflight", inflight, exp_q.size());
    check("idle", idle, m_state == IDLE);
    check("state", state, m_state);
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst_ready", req_ready, 0);
    check("rst_alu_valid", alu_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_idle", idle, 1);
    check("rst_inflight", inflight, 0);
    check("rst_b_idle", b_idle, 1);
    check("rst_b_inflight", b_inflight, 0);
    check("rst_b_rsp_valid", b_rsp_valid, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    due_q.delete();
    m_state = IDLE; m_ptr = 3;
    m_alu_a = '0; m_alu_sel = '0; m_rsp_id = '0; m_rsp_res = '0;
    #2 rst_n = 1'b1;
  endtask

  // ---------------- directed / random sequence ----------------
  initial begin
    int guard;
    repeat (2) @(negedge clk);
    apply_reset();
    step();

    // single request from requester 2: a=3, select=1 -> result 4'b0111
    en = 1'b1;
    step();
    req_valid = 4'b0100; req_a = 8'b0011_0000; req_sel = 8'b0001_0000;
    step();
    req_valid = 4'b0000;
    repeat (4) step();

    // all four requesters valid continuously
    req_a = 8'($urandom); req_sel = 8'($urandom);
    req_valid = 4'hF;
    repeat (12) step();

    // requesters 1 and 3 competing
    req_valid = 4'b1010;
    repeat (8) step();

    // random traffic with occasional enable drops
    for (int i = 0; i < 300; i++) begin
      en        = ($urandom_range(0, 15) != 0);
      req_valid = 4'($urandom);
      req_a     = 8'($urandom);
      req_sel   = 8'($urandom);
      step();
    end

    // drain with operations in flight
    en = 1'b1; req_valid = 4'hF;
    repeat (4) step();
    en = 1'b0;
    repeat (8) step();
    check("drain_idle", idle, 1);
    check("drain_inflight", inflight, 0);

    // reset with two operations in flight
    en = 1'b1; req_valid = 4'hF;
    guard = 0;
    while (exp_q.size() != 2 && guard < 10) begin
      step();
      guard++;
    end
    check("two_inflight", inflight, 2);
    req_valid = 4'b0000;
    apply_reset();
    repeat (6) step();
    en = 1'b0;
    repeat (3) step();

    // zero-latency instance: requester 1 back-to-back
    b_en = 1'b1;
    step();
    check("b_run", b_idle, 0);
    b_req_valid = 4'b0010; b_req_a = 8'h04; b_req_sel = 8'h08;
    #1 check("b_ready1", b_req_ready, 4'b0010);
    step();
    check("b_issue1", b_alu_valid, 1);
    check("b_infl1", b_inflight, 1);
    check("b_norsp1", b_rsp_valid, 0);
    #1 check("b_ready2", b_req_ready, 4'b0010);
    step();
    check("b_rsp2", b_rsp_valid, 1);
    check("b_id2", b_rsp_id, 1);
    check("b_res2", b_rsp_result, 4'b1001);
    check("b_infl2", b_inflight, 1);
    b_req_a = 8'h08; b_req_sel = 8'h0C;
    step();
    check("b_res3", b_rsp_result, 4'b1001);
    check("b_infl3", b_inflight, 1);
    b_req_valid = 4'b0000;
    step();
    check("b_rsp4", b_rsp_valid, 1);
    check("b_res4", b_rsp_result, 4'b1110);
    check("b_infl4", b_inflight, 0);
    check("b_noissue4", b_alu_valid, 0);
    step();
    check("b_norsp5", b_rsp_valid, 0);
    b_en = 1'b0;
    repeat (2) step();
    check("b_idle", b_idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single DSP-mapped arithmetic unit (2-bit operand, 2-bit select, 4-bit result) between N_REQ requesters. The block arbitrates valid/ready requests, issues at most one operation per cycle to the ALU, tracks each in-flight operation through the ALU's fixed pipeline latency, and returns each result tagged with its requester ID. It sits between the requesting control logic and the existing ALU top level. An enable/drain state machine lets software quiesce the unit cleanly.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- LAT, 2: number of ALU pipeline cycles from `o_alu_*` to `i_alu_result`, 0..4.
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_en  in  1  enable; low requests a drain to idle.
- i_req_valid  in  N_REQ  per-requester request valid.
- i_req_a  in  2*N_REQ  operands; requester r uses bits [2r+1:2r].
- i_req_select  in  2*N_REQ  ALU selects; same packing as `i_req_a`.
- o_req_ready  out  N_REQ  grant; at most one bit is high.
- o_alu_valid  out  1  issue strobe to the ALU.
- o_alu_a  out  2  registered operand to the ALU.
- o_alu_select  out  2  registered select to the ALU.
- i_alu_result  in  4  ALU result.
- o_rsp_valid  out  1  result strobe; there is no backpressure.
- o_rsp_id  out  IDW  requester ID, where IDW = max(1, clog2(N_REQ)).
- o_rsp_result  out  4  registered result.
- o_idle  out  1  high in IDLE only.
- o_inflight  out  3  number of operations issued but not yet responded.

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset state is IDLE.
  - IDLE → RUN when `i_en`=1.
  - RUN → DRAIN when `i_en`=0.
  - DRAIN → IDLE when the pipeline is empty and `i_en`=0.
  - DRAIN → RUN when the pipeline is empty and `i_en`=1.
  - DRAIN always completes before any new grant is made.
- Grants are made only in RUN. `o_req_ready[w]` is combinational and equals RUN & (w = winner among `i_req_valid`). Ready may depend on valid.
- An accept is `i_req_valid[w]` & `o_req_ready[w]` at a rising edge. On that edge `o_alu_a`, `o_alu_select` and `o_alu_valid` are loaded from requester w. In cycles with no accept, `o_alu_valid` is 0 and `o_alu_a`/`o_alu_select` hold their values.
- Tag pipeline: LAT+1 stages, each holding {valid, id}. It shifts every cycle. There are no stalls.
- Throughput: one accept per cycle.
- At the capture edge, `o_rsp_result` ← `i_alu_result` and `o_rsp_id` ← stage id. The arbiter does no arithmetic; the result is a pure pass-through.
- `o_inflight` increments on accept, decrements on response, and is unchanged when both occur in the same cycle.
- Round-robin: a pointer holds the last granted index, and the search starts at pointer+1 modulo N_REQ. The pointer updates only on an accept. Its reset value is N_REQ-1, so requester 0 wins first.
- A requester holding valid without a grant must keep its a/select stable. The arbiter does not check this.
- Reset mid-operation: all in-flight operations are discarded and no response is produced for them.

## Timing
- Accept on edge k → `o_alu_valid` high in cycle k+1 → `i_alu_result` sampled at edge k+1+LAT → `o_rsp_valid` high for exactly one cycle after edge k+1+LAT.
- Accept-to-response latency is LAT+1 edges.
- Back-to-back accepts produce back-to-back responses, in accept order.
- `i_en` falling in cycle c: no grant is made at edge c. The FSM enters DRAIN at edge c, and `o_idle` rises one cycle after the last `o_rsp_valid`.
- Reset values:
  - `o_req_ready`=0, `o_alu_valid`=0, `o_alu_a`=0, `o_alu_select`=0
  - `o_rsp_valid`=0, `o_rsp_id`=0, `o_rsp_result`=0
  - `o_idle`=1, `o_inflight`=0

## Configuration
- ALU_SHARE_ARBITER_RR_EN defined: round-robin arbitration as described above.
- ALU_SHARE_ARBITER_RR_EN undefined: fixed priority, lowest index wins. The pointer register is not built.
- All other behaviour is identical in both cases.

## Structure
- Package `alu_share_pkg`:
  - constants ALU_A_W=2, ALU_SEL_W=2, ALU_RES_W=4;
  - enum `arb_state_t` {IDLE, RUN, DRAIN};
  - tag struct {valid, id}.
- Sub-module `alu_rr_arbiter` is parameterised on N_REQ. It takes request, advance and state inputs, outputs a one-hot grant, and contains the pointer register.

## Test plan
The bench uses an ALU stub with latency LAT that returns {select, a}.
- Single request, N_REQ=4, LAT=2: requester 2 sends a=2'b11, select=2'b01, accepted at edge k → `o_rsp_valid` at edge k+3 with id=2 and result=4'b0111.
- All four requesters valid continuously (RR_EN defined) → grant order 0,1,2,3,0,…; one response per cycle; ids in the same order.
- RR_EN undefined, requesters 1 and 3 valid → requester 1 is granted every cycle and requester 3 is starved.
- Drain: drop `i_en` with 3 operations in flight → no new ready; 3 responses are delivered; `o_idle`=1 one cycle after the last response; `o_inflight`=0.
- Reset asserted with 2 operations in flight → all outputs are at reset values immediately; no response appears after release.
- LAT=0 → accept at edge k gives a response at edge k+1. Accept and response in the same cycle leave `o_inflight` unchanged.
